// File: rtl/txarb_pkg.sv
// Shared types and defaults for the txuart arbiter family: FSM encoding,
// default parameter values and a saturating counter helper.
package txarb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    XMIT  = 2'd2,
    GUARD = 2'd3
  } arb_state_t;

  localparam int         DEF_NREQ     = 4;
  localparam logic [7:0] DEF_EOM_BYTE = 8'h0a;
  localparam int         DEF_HOLD     = 16;
  localparam int         DEF_MAXBURST = 64;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request bit strictly
// after 'last', wrapping modulo N. Produces a one-hot grant and its index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    // Offset 1..N so the previous winner is scanned last.
    for (int i = 1; i <= N; i++) begin
      if (!found && req[(int'(last) + i) % N]) begin
        found                       = 1'b1;
        grant[(int'(last) + i) % N] = 1'b1;
        idx                         = IW'((int'(last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/txuart_arbiter.sv
// Round-robin, message-locked sharing of one txuart among NREQ byte streams.
// Define TXARB_MAXBURST_EN to cap bytes per grant when others are waiting.
module txuart_arbiter
  import txarb_pkg::*;
#(
  parameter int         NREQ     = DEF_NREQ,
  parameter logic [7:0] EOM_BYTE = DEF_EOM_BYTE,
  parameter int         HOLD     = DEF_HOLD
`ifdef TXARB_MAXBURST_EN
  , parameter int       MAXBURST = DEF_MAXBURST
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_stb,
  input  logic [8*NREQ-1:0] i_req_data,
  output logic [NREQ-1:0]   o_req_ack,
  output logic [NREQ-1:0]   o_grant,
  output logic              o_tx_stb,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_busy,
  output logic              o_active
);

  localparam int         IW        = $clog2(NREQ);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  arb_state_t      state_reg, state_next;
  logic [NREQ-1:0] grant_reg, grant_next;
  logic [NREQ-1:0] ack_reg, ack_next;
  logic [IW-1:0]   last_reg, last_next;
  logic [7:0]      hold_reg, hold_next;
  logic            tx_stb_reg, tx_stb_next;
  logic [7:0]      tx_data_reg, tx_data_next;
  logic            release_reg, release_next;
`ifdef TXARB_MAXBURST_EN
  localparam logic [7:0] BURST_LIMIT = 8'(MAXBURST);
  logic [7:0]      burst_reg, burst_next;
`endif

  logic [7:0]      req_byte [NREQ];
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            sel_stb;
  logic [7:0]      sel_byte;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
    assign req_byte[gi] = i_req_data[8*gi +: 8];
  end

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req   (i_req_stb),
    .last  (last_reg),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // last_reg always names the current owner while a grant is held.
  assign sel_stb  = |(i_req_stb & grant_reg);
  assign sel_byte = req_byte[last_reg];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      ack_reg     <= '0;
      last_reg    <= IW'(NREQ - 1);
      hold_reg    <= '0;
      tx_stb_reg  <= 1'b0;
      tx_data_reg <= '0;
      release_reg <= 1'b0;
`ifdef TXARB_MAXBURST_EN
      burst_reg   <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      ack_reg     <= ack_next;
      last_reg    <= last_next;
      hold_reg    <= hold_next;
      tx_stb_reg  <= tx_stb_next;
      tx_data_reg <= tx_data_next;
      release_reg <= release_next;
`ifdef TXARB_MAXBURST_EN
      burst_reg   <= burst_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    ack_next     = '0;
    last_next    = last_reg;
    hold_next    = hold_reg;
    tx_stb_next  = tx_stb_reg;
    tx_data_next = tx_data_reg;
    release_next = release_reg;
`ifdef TXARB_MAXBURST_EN
    burst_next   = burst_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (|i_req_stb) begin
          grant_next = pick_grant;
          last_next  = pick_idx;
          hold_next  = '0;
`ifdef TXARB_MAXBURST_EN
          burst_next = '0;
`endif
          state_next = SEND;
        end
      end
      SEND: begin
        if (sel_stb) begin
          tx_data_next = sel_byte;
          tx_stb_next  = 1'b1;
          ack_next     = grant_reg;
          hold_next    = '0;
`ifdef TXARB_MAXBURST_EN
          burst_next   = sat_inc8(burst_reg);
`endif
          state_next   = XMIT;
        end else if (hold_reg >= HOLD_LAST) begin
          grant_next = '0;
          state_next = IDLE;
        end else begin
          hold_next = sat_inc8(hold_reg);
        end
      end
      XMIT: begin
        if (!i_tx_busy) begin
          tx_stb_next  = 1'b0;
          tx_data_next = '0;
          release_next = (tx_data_reg == EOM_BYTE);
          state_next   = GUARD;
        end
      end
      GUARD: begin
        // Gives txuart one cycle to raise busy before the next capture.
        if (release_reg) begin
          grant_next = '0;
          state_next = IDLE;
        end
`ifdef TXARB_MAXBURST_EN
        else if (burst_reg >= BURST_LIMIT) begin
          if (|(i_req_stb & ~grant_reg)) begin
            grant_next = '0;
            state_next = IDLE;
          end else begin
            burst_next = '0;
            state_next = SEND;
          end
        end
`endif
        else begin
          state_next = SEND;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_req_ack = ack_reg;
  assign o_grant   = grant_reg;
  assign o_tx_stb  = tx_stb_reg;
  assign o_tx_data = tx_data_reg;
  assign o_active  = (state_reg != IDLE);

endmodule
